morra_cinese_n: RTL and testbench

MORRA_CINESE_N -- requirements
Module: morra_cinese_n

---
 rtl/morra_pkg.sv | 32 +++
 rtl/morra_giudice.sv | 34 +++
 rtl/morra_cinese_n.sv | 146 ++++++++++++++
 tb/tb_morra_cinese_n.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/morra_pkg.sv
// Shared encodings, FSM state type and the round-judging rule for morra cinese.
package morra_pkg;

    localparam logic [1:0] MV_NONE    = 2'b00;
    localparam logic [1:0] MV_SASSO   = 2'b01;
    localparam logic [1:0] MV_CARTA   = 2'b10;
    localparam logic [1:0] MV_FORBICE = 2'b11;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_PRIMO   = 2'b01;
    localparam logic [1:0] RES_SECONDO = 2'b10;
    localparam logic [1:0] RES_DRAW    = 2'b11;

    typedef enum logic [1:0] {
        INIZIO = 2'd0,
        GIOCO  = 2'd1,
        FINE   = 2'd2
    } state_t;

    // Result of two non-empty moves: carta > sasso, forbice > carta, sasso > forbice.
    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == b)
            return RES_DRAW;
        else if ((a == MV_CARTA   && b == MV_SASSO)   ||
                 (a == MV_FORBICE && b == MV_CARTA)   ||
                 (a == MV_SASSO   && b == MV_FORBICE))
            return RES_PRIMO;
        else
            return RES_SECONDO;
    endfunction

endpackage

// File: rtl/morra_giudice.sv
// Combinational round judge: classifies a move pair as abort, invalid or a counted result.
module morra_giudice
    import morra_pkg::*;
#(
    parameter int NO_REPEAT = 1
) (
    input  logic [1:0] i_primo,
    input  logic [1:0] i_secondo,
    input  logic [1:0] i_last_win,
    input  logic [1:0] i_last_move,
    output logic       o_abort,
    output logic       o_valid,
    output logic [1:0] o_res
);

    logic w_repeat;

    // Classify the round; a last winner replaying its winning move is rejected.
    always_comb begin
        o_abort  = 1'b0;
        o_valid  = 1'b0;
        o_res    = RES_NONE;
        w_repeat = (NO_REPEAT != 0) &&
                   ((i_last_win == RES_PRIMO   && i_primo   == i_last_move) ||
                    (i_last_win == RES_SECONDO && i_secondo == i_last_move));
        if (i_primo == MV_NONE && i_secondo == MV_NONE) begin
            o_abort = 1'b1;
        end else if (i_primo != MV_NONE && i_secondo != MV_NONE && !w_repeat) begin
            o_valid = 1'b1;
            o_res   = judge(i_primo, i_secondo);
        end
    end

endmodule

// File: rtl/morra_cinese_n.sv
// Morra cinese game controller: counts valid rounds, tracks a saturating lead, decides the game.
module morra_cinese_n
    import morra_pkg::*;
#(
    parameter int WIN_LEAD   = 2,
    parameter int MIN_MANCHE = 4,
    parameter int CFG_W      = 4,
    parameter int NO_REPEAT  = 1,
    localparam int CNT_W     = $clog2(2**CFG_W + MIN_MANCHE),
    localparam int LEAD_W    = $clog2(WIN_LEAD + 1) + 1
) (
    input  logic                     clk,
    input  logic                     inizio,
    input  logic [CFG_W-1:0]         config_max,
    input  logic [1:0]               primo,
    input  logic [1:0]               secondo,
    output logic [1:0]               manche,
    output logic [1:0]               partita,
    output logic [CNT_W-1:0]         conteggio,
    output logic signed [LEAD_W-1:0] vantaggio
);

    localparam logic signed [LEAD_W-1:0] LEAD_MAX = LEAD_W'(WIN_LEAD);
    localparam logic signed [LEAD_W-1:0] LEAD_MIN = -LEAD_MAX;
    localparam logic signed [LEAD_W-1:0] LEAD_ONE = LEAD_W'(1);

    state_t                   r_state, w_state_nx;
    logic [CNT_W-1:0]         r_limit, w_limit_nx;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nx;
    logic signed [LEAD_W-1:0] r_lead, w_lead_nx;
    logic [1:0]               r_last_win, w_last_win_nx;
    logic [1:0]               r_last_move, w_last_move_nx;
    logic [1:0]               r_manche, w_manche_nx;
    logic [1:0]               r_partita, w_partita_nx;

    logic                     w_abort;
    logic                     w_valid;
    logic [1:0]               w_res;

    function automatic logic [1:0] by_sign(input logic signed [LEAD_W-1:0] v);
        if (v == '0)
            return RES_DRAW;
        else if (v[LEAD_W-1])
            return RES_SECONDO;
        else
            return RES_PRIMO;
    endfunction

    morra_giudice #(
        .NO_REPEAT (NO_REPEAT)
    ) u_giudice (
        .i_primo     (primo),
        .i_secondo   (secondo),
        .i_last_win  (r_last_win),
        .i_last_move (r_last_move),
        .o_abort     (w_abort),
        .o_valid     (w_valid),
        .o_res       (w_res)
    );

    // State and all output-facing registers; inizio clears everything asynchronously.
    always_ff @(posedge clk or posedge inizio) begin
        if (inizio) begin
            r_state     <= INIZIO;
            r_limit     <= '0;
            r_cnt       <= '0;
            r_lead      <= '0;
            r_last_win  <= RES_NONE;
            r_last_move <= MV_NONE;
            r_manche    <= RES_NONE;
            r_partita   <= RES_NONE;
        end else begin
            r_state     <= w_state_nx;
            r_limit     <= w_limit_nx;
            r_cnt       <= w_cnt_nx;
            r_lead      <= w_lead_nx;
            r_last_win  <= w_last_win_nx;
            r_last_move <= w_last_move_nx;
            r_manche    <= w_manche_nx;
            r_partita   <= w_partita_nx;
        end
    end

    // Next-state and next-output logic; an early lead decision outranks the round limit.
    always_comb begin
        w_state_nx     = r_state;
        w_limit_nx     = r_limit;
        w_cnt_nx       = r_cnt;
        w_lead_nx      = r_lead;
        w_last_win_nx  = r_last_win;
        w_last_move_nx = r_last_move;
        w_manche_nx    = RES_NONE;
        w_partita_nx   = r_partita;
        case (r_state)
            INIZIO: begin
                w_state_nx     = GIOCO;
                w_limit_nx     = CNT_W'(config_max) + CNT_W'(MIN_MANCHE);
                w_cnt_nx       = '0;
                w_lead_nx      = '0;
                w_last_win_nx  = RES_NONE;
                w_last_move_nx = MV_NONE;
                w_partita_nx   = RES_NONE;
            end
            GIOCO: begin
                if (w_abort) begin
                    w_state_nx   = FINE;
                    w_partita_nx = by_sign(r_lead);
                end else if (w_valid) begin
                    w_manche_nx = w_res;
                    w_cnt_nx    = r_cnt + 1'b1;
                    if (w_res == RES_PRIMO && r_lead != LEAD_MAX)
                        w_lead_nx = r_lead + LEAD_ONE;
                    else if (w_res == RES_SECONDO && r_lead != LEAD_MIN)
                        w_lead_nx = r_lead - LEAD_ONE;
                    if (w_res == RES_DRAW) begin
                        w_last_win_nx  = RES_NONE;
                        w_last_move_nx = MV_NONE;
                    end else begin
                        w_last_win_nx  = w_res;
                        w_last_move_nx = (w_res == RES_PRIMO) ? primo : secondo;
                    end
                    if (w_cnt_nx >= CNT_W'(MIN_MANCHE) &&
                        (w_lead_nx >= LEAD_MAX || w_lead_nx <= LEAD_MIN)) begin
                        w_state_nx   = FINE;
                        w_partita_nx = by_sign(w_lead_nx);
                    end else if (w_cnt_nx == r_limit) begin
                        w_state_nx   = FINE;
                        w_partita_nx = by_sign(w_lead_nx);
                    end
                end
            end
            FINE: begin
                w_state_nx = FINE;
            end
            default: begin
                w_state_nx = INIZIO;
            end
        endcase
    end

    assign manche    = r_manche;
    assign partita   = r_partita;
    assign conteggio = r_cnt;
    assign vantaggio = r_lead;

endmodule

// File: tb/tb_morra_cinese_n.sv
// Directed self-checking bench for morra_cinese_n (default and NO_REPEAT=0/WIN_LEAD=3 builds).
module tb_morra_cinese_n;

    logic              clk = 1'b0;
    logic              inizio, inizio2;
    logic [3:0]        cfg, cfg2;
    logic [1:0]        p, s, p2, s2;
    logic [1:0]        m1, pt1, m2, pt2;
    logic [4:0]        c1, c2;
    logic signed [2:0] v1, v2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    morra_cinese_n u_dut (
        .clk        (clk),
        .inizio     (inizio),
        .config_max (cfg),
        .primo      (p),
        .secondo    (s),
        .manche     (m1),
        .partita    (pt1),
        .conteggio  (c1),
        .vantaggio  (v1)
    );

    morra_cinese_n #(
        .WIN_LEAD  (3),
        .NO_REPEAT (0)
    ) u_dut2 (
        .clk        (clk),
        .inizio     (inizio2),
        .config_max (cfg2),
        .primo      (p2),
        .secondo    (s2),
        .manche     (m2),
        .partita    (pt2),
        .conteggio  (c2),
        .vantaggio  (v2)
    );

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input integer m, input integer pt, input integer c, input integer v);
        chk({tag, ".manche"},    m1,  m);
        chk({tag, ".partita"},   pt1, pt);
        chk({tag, ".conteggio"}, c1,  c);
        chk({tag, ".vantaggio"}, v1,  v);
    endtask

    task automatic chk2(input string tag, input integer m, input integer pt, input integer c, input integer v);
        chk({tag, ".manche"},    m2,  m);
        chk({tag, ".partita"},   pt2, pt);
        chk({tag, ".conteggio"}, c2,  c);
        chk({tag, ".vantaggio"}, v2,  v);
    endtask

    task automatic step1(input logic [1:0] a, input logic [1:0] b);
        p = a;
        s = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [1:0] a, input logic [1:0] b);
        p2 = a;
        s2 = b;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges, then one INIZIO edge with moves that must be ignored.
    task automatic start1(input string tag, input logic [3:0] c);
        cfg    = c;
        p      = 2'b10;
        s      = 2'b01;
        inizio = 1'b1;
        #2;
        chk1({tag, ".rst"}, 0, 0, 0, 0);
        inizio = 1'b0;
        @(posedge clk);
        #1;
        chk1({tag, ".init"}, 0, 0, 0, 0);
    endtask

    initial begin
        inizio  = 1'b0;
        inizio2 = 1'b0;
        cfg     = 4'd0;
        cfg2    = 4'd0;
        p       = 2'b00;
        s       = 2'b00;
        p2      = 2'b00;
        s2      = 2'b00;
        #1;
        inizio  = 1'b1;
        inizio2 = 1'b1;
        #1;
        chk1("por", 0, 0, 0, 0);
        chk2("por2", 0, 0, 0, 0);

        // Primo wins four rounds with changing moves; lead saturates at 2.
        start1("g1", 4'd0);
        step1(2'b10, 2'b01); chk1("g1.r1", 1, 0, 1, 1);
        step1(2'b11, 2'b10); chk1("g1.r2", 1, 0, 2, 2);
        step1(2'b01, 2'b11); chk1("g1.r3", 1, 0, 3, 2);
        step1(2'b10, 2'b01); chk1("g1.r4", 1, 1, 4, 2);
        step1(2'b01, 2'b10); chk1("g1.fine", 0, 1, 4, 2);

        // Winner repeating its winning move is not counted; secondo then wins normally.
        start1("g2", 4'd0);
        step1(2'b10, 2'b01); chk1("g2.r1", 1, 0, 1, 1);
        step1(2'b10, 2'b11); chk1("g2.rep", 0, 0, 1, 1);
        step1(2'b01, 2'b10); chk1("g2.r3", 2, 0, 2, 0);

        // Four draws reach the limit with zero lead.
        start1("g3", 4'd0);
        step1(2'b01, 2'b01); chk1("g3.r1", 3, 0, 1, 0);
        step1(2'b01, 2'b01); chk1("g3.r2", 3, 0, 2, 0);
        step1(2'b01, 2'b01); chk1("g3.r3", 3, 0, 3, 0);
        step1(2'b01, 2'b01); chk1("g3.r4", 3, 3, 4, 0);

        // Single empty move is ignored; double empty aborts; FINE ignores later moves.
        start1("g4", 4'd0);
        step1(2'b10, 2'b01); chk1("g4.r1", 1, 0, 1, 1);
        step1(2'b00, 2'b10); chk1("g4.one0", 0, 0, 1, 1);
        step1(2'b00, 2'b00); chk1("g4.abort", 0, 1, 1, 1);
        step1(2'b01, 2'b10); chk1("g4.hold1", 0, 1, 1, 1);
        step1(2'b11, 2'b11); chk1("g4.hold2", 0, 1, 1, 1);

        // Secondo wins to negative saturation; lead reaching -2 ends the game.
        start1("g5", 4'd15);
        step1(2'b01, 2'b10); chk1("g5.r1", 2, 0, 1, -1);
        step1(2'b10, 2'b11); chk1("g5.r2", 2, 0, 2, -2);
        step1(2'b11, 2'b01); chk1("g5.r3", 2, 0, 3, -2);
        step1(2'b01, 2'b10); chk1("g5.r4", 2, 2, 4, -2);

        // Reset mid-game clears outputs before any edge; next game latches limit 6.
        start1("g6", 4'd1);
        step1(2'b10, 2'b01); chk1("g6.r1", 1, 0, 1, 1);
        start1("g7", 4'd2);
        step1(2'b11, 2'b11); chk1("g7.r1", 3, 0, 1, 0);
        step1(2'b11, 2'b11); chk1("g7.r2", 3, 0, 2, 0);
        step1(2'b11, 2'b11); chk1("g7.r3", 3, 0, 3, 0);
        step1(2'b11, 2'b11); chk1("g7.r4", 3, 0, 4, 0);
        step1(2'b11, 2'b11); chk1("g7.r5", 3, 0, 5, 0);
        step1(2'b11, 2'b11); chk1("g7.r6", 3, 3, 6, 0);

        // Repeats allowed, WIN_LEAD=3: lead 3 reached early, game decided only at round 4.
        cfg2    = 4'd5;
        p2      = 2'b10;
        s2      = 2'b01;
        inizio2 = 1'b0;
        @(posedge clk);
        #1;
        chk2("g8.init", 0, 0, 0, 0);
        step2(2'b10, 2'b01); chk2("g8.r1", 1, 0, 1, 1);
        step2(2'b10, 2'b01); chk2("g8.r2", 1, 0, 2, 2);
        step2(2'b10, 2'b01); chk2("g8.r3", 1, 0, 3, 3);
        step2(2'b10, 2'b01); chk2("g8.r4", 1, 1, 4, 3);
        step2(2'b10, 2'b01); chk2("g8.fine", 0, 1, 4, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
